// File: rtl/gen_gray_pkg.sv
// Shared helpers for the gray-pointer receiver: gray/binary conversion,
// popcount and the receiver FSM state constants.
// Latency: n/a (pure functions and constants). Backpressure: n/a.
//
// The functions operate on a fixed GMAX_W-bit vector so they stay
// width-generic. Callers zero-extend narrower values with a size cast and
// truncate the result with a size cast. Leading zeros do not disturb the
// low bits of any of these functions.
package gen_gray_pkg;

  localparam int GMAX_W   = 32;
  localparam int POPCNT_W = $clog2(GMAX_W + 1);

  // Receiver FSM encoding. Plain constants keep the encoding visible to
  // legacy tooling and scripts that match on raw state values.
  localparam logic [0:0] WARMUP = 1'b0;
  localparam logic [0:0] RUN    = 1'b1;

  // bin[i] = XOR of g[MSB:i], built as a running XOR from the top bit down.
  function automatic logic [GMAX_W-1:0] gray2bin(input logic [GMAX_W-1:0] g);
    logic [GMAX_W-1:0] b;
    b[GMAX_W-1] = g[GMAX_W-1];
    for (int i = GMAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GMAX_W-1:0] bin2gray(input logic [GMAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [POPCNT_W-1:0] popcount(input logic [GMAX_W-1:0] v);
    logic [POPCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < GMAX_W; i++) begin
      c = c + POPCNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gen_gray_ptr_rcvr_if.sv
// Bundle of the gray-pointer receiver's data-path signals.
// Latency: n/a (wires only). Backpressure: none; the pointer is free-running.
//
// Signals:
//   gray_in    - gray count from the source domain (asynchronous to clk)
//   err_clr    - clears err_sticky (clk domain)
//   gray_sync  - last synchronized gray value
//   bin_out    - registered binary decode of gray_sync
//   advance    - one-cycle pulse when bin_out changes
//   delta      - modular bin_out increment, valid with advance, else 0
//   gray_err   - one-cycle pulse on a multi-bit gray transition
//   err_sticky - latched gray_err, held until err_clr
// The master modport drives the inputs; the slave modport is the receiver.
interface gen_gray_ptr_rcvr_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic             err_clr;
  logic [WIDTH-1:0] gray_sync;
  logic [WIDTH-1:0] bin_out;
  logic             advance;
  logic [WIDTH-1:0] delta;
  logic             gray_err;
  logic             err_sticky;

  modport master (
    output gray_in,
    output err_clr,
    input  gray_sync,
    input  bin_out,
    input  advance,
    input  delta,
    input  gray_err,
    input  err_sticky
  );

  modport slave (
    input  gray_in,
    input  err_clr,
    output gray_sync,
    output bin_out,
    output advance,
    output delta,
    output gray_err,
    output err_sticky
  );
endinterface

// File: rtl/gen_sync_bus.sv
// Multi-flop synchronizer chain for a bus whose value changes one bit at a
// time (gray code). Latency: SYNC_STAGES clk edges. Backpressure: none.
//
// Ports:
//   clk    - destination clock
//   reset  - asynchronous, active-high reset; clears every stage to 0
//   din    - bus from the foreign clock domain
//   dout   - last stage of the chain
// No logic sits between stages so every flop gets a full cycle to resolve.
module gen_sync_bus #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gen_gray_ptr_rcvr.sv
// Gray-pointer receiver: synchronize, decode, report advance/delta and
// flag illegal multi-bit gray steps.
// Latency: gray_in stable before edge k shows on gray_sync/bin_out after
// edge k+SYNC_STAGES. Backpressure: none; every synchronized change is
// reported the cycle it lands.
//
// Ports:
//   clk   - destination-domain clock
//   reset - asynchronous, active-high reset
//   bus   - gen_gray_ptr_rcvr_if.slave (gray_in, err_clr in; gray_sync,
//           bin_out, advance, delta, gray_err, err_sticky out)
// Build option GEN_GRAY_RCVR_CHK_EN: when defined, the popcount checker
// driving gray_err/err_sticky is built. When undefined both outputs are tied
// 0 and err_clr is ignored.
module gen_gray_ptr_rcvr
  import gen_gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  gen_gray_ptr_rcvr_if.slave  bus
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  logic [WIDTH-1:0] s_gray;
  logic [WIDTH-1:0] s_bin;

  logic [0:0]       state_q,     state_d;
  logic [CW-1:0]    wcnt_q,      wcnt_d;
  logic [WIDTH-1:0] gray_sync_q, gray_sync_d;
  logic [WIDTH-1:0] bin_out_q,   bin_out_d;
  logic             advance_q,   advance_d;
  logic [WIDTH-1:0] delta_q,     delta_d;

  gen_sync_bus #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.gray_in),
    .dout  (s_gray)
  );

  // Decode straight off the synchronizer output; the registered copy is
  // bin_out, so the decode never sees a metastable input.
  assign s_bin = WIDTH'(gray2bin(GMAX_W'(s_gray)));

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    gray_sync_d = gray_sync_q;
    bin_out_d   = bin_out_q;
    advance_d   = 1'b0;
    delta_d     = '0;

    case (state_q)
      WARMUP: begin
        // The chain still holds reset zeros, so outputs just track it
        // without reporting movement.
        gray_sync_d = s_gray;
        bin_out_d   = s_bin;
        wcnt_d      = wcnt_q + CW'(1);
        if (wcnt_q == CW'(SYNC_STAGES - 1)) begin
          state_d = RUN;
        end
      end
      default: begin
        if (s_gray != gray_sync_q) begin
          gray_sync_d = s_gray;
          bin_out_d   = s_bin;
          advance_d   = 1'b1;
          // Modular difference; a backward step shows up as a large delta.
          delta_d     = s_bin - bin_out_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WARMUP;
      wcnt_q      <= '0;
      gray_sync_q <= '0;
      bin_out_q   <= '0;
      advance_q   <= 1'b0;
      delta_q     <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      gray_sync_q <= gray_sync_d;
      bin_out_q   <= bin_out_d;
      advance_q   <= advance_d;
      delta_q     <= delta_d;
    end
  end

  assign bus.gray_sync = gray_sync_q;
  assign bus.bin_out   = bin_out_q;
  assign bus.advance   = advance_q;
  assign bus.delta     = delta_q;

`ifdef GEN_GRAY_RCVR_CHK_EN
  logic gray_err_q,   gray_err_d;
  logic err_sticky_q, err_sticky_d;

  always_comb begin
    // More than one flipped bit between consecutive synchronized samples
    // means the source broke gray discipline or the crossing is unsafe.
    gray_err_d   = (state_q == RUN) &&
                   (popcount(GMAX_W'(s_gray ^ gray_sync_q)) > POPCNT_W'(1));
    // A new error outranks a clear arriving in the same cycle.
    err_sticky_d = gray_err_d | (err_sticky_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      gray_err_q   <= gray_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.gray_err   = gray_err_q;
  assign bus.err_sticky = err_sticky_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.gray_err   = 1'b0;
  assign bus.err_sticky = 1'b0;
`endif

endmodule
